cordiv_array: RTL

CORDIV_ARRAY -- requirements
Module: cordiv_array

---
 rtl/cordiv_array.sv | 128 ++++++++++++
 1 files changed

// File: rtl/cordiv_array.sv
// Array of correlated-bitstream (CORDIV) stochastic dividers sharing one LFSR for history selection.
// Define CORDIV_CNT_EN to compile in the per-channel ones-counter with its cnt_* ports.
module cordiv_array #(
  parameter  int NCH     = 4,
  parameter  int SRDEPTH = 4,
  parameter  int CNTW    = 8,
  localparam int SELW    = $clog2(SRDEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  sel_mode,
  input  logic [NCH*SELW-1:0]   sel,
  input  logic [NCH-1:0]        dividend,
  input  logic [NCH-1:0]        divisor,
  output logic [NCH-1:0]        quotient
`ifdef CORDIV_CNT_EN
  ,
  input  logic                  cnt_start,
  output logic                  cnt_busy,
  output logic                  cnt_done,
  output logic [NCH*(CNTW+1)-1:0] cnt_val
`endif
);

  if (NCH < 1 || NCH > 8 || SRDEPTH < 2 || SRDEPTH > 16 || CNTW < 4 || CNTW > 16) begin : g_bad_param
    $error("cordiv_array: parameter out of range");
  end

  function automatic logic [7:0] lfsr_next(input logic [7:0] v);
    return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
  endfunction

  function automatic logic [7:0] rotr8(input logic [7:0] v, input logic [2:0] n);
    logic [15:0] d;
    d = {v, v} >> n;
    return d[7:0];
  endfunction

  function automatic logic [SELW-1:0] clamp_idx(input logic [SELW-1:0] raw);
    if ({1'b0, raw} >= (SELW+1)'(SRDEPTH))
      return (SELW)'(SRDEPTH - 1);
    return raw;
  endfunction

  logic [7:0] lfsr;

  // Shared selector LFSR: advances on every enabled edge regardless of sel_mode
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      lfsr <= 8'hA5;
    else if (en)
      lfsr <= lfsr_next(lfsr);
  end

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    logic [SRDEPTH-1:0] sr;
    logic [7:0]         rot;
    logic [SELW-1:0]    raw;
    logic [SELW-1:0]    idx;
    logic               q;

    always_comb begin
      rot = rotr8(lfsr, 3'(i));
      raw = sel_mode ? rot[SELW-1:0] : sel[i*SELW +: SELW];
      idx = clamp_idx(raw);
      q   = divisor[i] ? dividend[i] : sr[idx];
    end

    assign quotient[i] = q;

    // History only records cycles where the divisor bit was present
    always_ff @(posedge clk or posedge rst) begin
      if (rst)
        sr <= '0;
      else if (en && divisor[i])
        sr <= {sr[SRDEPTH-2:0], q};
    end
  end

`ifdef CORDIV_CNT_EN
  logic [CNTW-1:0] win;
  logic [CNTW:0]   acc     [NCH];
  logic [CNTW:0]   acc_nxt [NCH];
  logic            start_ok;
  logic            last_add;

  always_comb begin
    start_ok = !cnt_busy && cnt_start;
    last_add = cnt_busy && en && (win == '1);
    for (int i = 0; i < NCH; i++)
      acc_nxt[i] = acc[i] + (CNTW+1)'(quotient[i]);
  end

  // Window control; the final add lands directly in cnt_val on the completing edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_busy <= 1'b0;
      cnt_done <= 1'b0;
      win      <= '0;
      cnt_val  <= '0;
    end else begin
      cnt_done <= last_add;
      if (start_ok) begin
        cnt_busy <= 1'b1;
        win      <= '0;
      end else if (cnt_busy && en) begin
        win <= win + 1'b1;
        if (last_add)
          cnt_busy <= 1'b0;
      end
      if (last_add)
        for (int i = 0; i < NCH; i++)
          cnt_val[i*(CNTW+1) +: CNTW+1] <= acc_nxt[i];
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NCH; i++) begin
      if (start_ok)
        acc[i] <= '0;
      else if (cnt_busy && en)
        acc[i] <= acc_nxt[i];
    end
  end
`endif

endmodule
